// File: rtl/axi_sram_slave.sv
// AXI4 slave SRAM model: word-addressed array behind independent read and write
// burst engines, one outstanding transaction per direction.
module axi_sram_slave #(
    parameter int    MEM_AW     = 12,
    parameter int    RD_LATENCY = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    // Every channel uses valid/ready: a transfer happens on a rising edge where
    // both are high; the sender holds its payload stable until then.

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_bad;
        wrap_bad = (burst == 2'b10) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size != 3'b010) || (burst == 2'b11) || wrap_bad;
    endfunction

    // WRAP keeps the bits above the (len+1)*4 boundary and wraps the bits below it.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        logic [31:0] res;
        mask = {22'd0, len, 2'b11};
        case (burst)
            2'b00:   res = addr;
            2'b10:   res = (addr & ~mask) | ((addr + 32'd4) & mask);
            default: res = addr + 32'd4;
        endcase
        return res;
    endfunction

    // ---------------- read engine ----------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

    r_state_t    r_state, r_state_nx;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_beat;
    logic [1:0]  r_burst;
    logic        r_err;
    logic [15:0] r_wait;
    logic        r_load;
    logic [31:0] r_load_addr;
    logic [7:0]  r_load_beat, r_cur_len;
    logic        r_cur_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx  = r_state;
        r_load      = 1'b0;
        r_load_addr = r_addr;
        r_load_beat = r_beat;
        r_cur_len   = r_len;
        r_cur_err   = r_err;
        case (r_state)
            R_IDLE: begin
                if (arvalid) begin
                    if (RD_LATENCY == 0) begin
                        r_state_nx  = R_BURST;
                        r_load      = 1'b1;
                        r_load_addr = araddr;
                        r_load_beat = 8'd0;
                        r_cur_len   = arlen;
                        r_cur_err   = burst_err(arlen, arsize, arburst);
                    end else begin
                        r_state_nx = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_wait == 16'd0) begin
                    r_state_nx  = R_BURST;
                    r_load      = 1'b1;
                    r_load_beat = 8'd0;
                end
            end
            R_BURST: begin
                if (rready) begin
                    if (r_beat == r_len) begin
                        r_state_nx = R_IDLE;
                    end else begin
                        r_load      = 1'b1;
                        r_load_addr = next_addr(r_addr, r_len, r_burst);
                        r_load_beat = r_beat + 8'd1;
                    end
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // The beat payload is captured from the array at the edge it is loaded, so a
    // write landing on that same edge is not seen: reads return pre-write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_wait  <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                rid     <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_burst <= arburst;
                r_err   <= burst_err(arlen, arsize, arburst);
                r_wait  <= 16'(RD_LATENCY > 0 ? RD_LATENCY - 1 : 0);
            end else if (r_state == R_WAIT && r_wait != 16'd0) begin
                r_wait <= r_wait - 16'd1;
            end
            if (r_load) begin
                r_addr <= r_load_addr;
                r_beat <= r_load_beat;
                rdata  <= r_cur_err ? 32'd0 : mem[r_load_addr[MEM_AW+1:2]];
                rresp  <= r_cur_err ? 2'b10 : 2'b00;
                rlast  <= (r_load_beat == r_cur_len);
            end
        end
    end

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t    w_state, w_state_nx;
    logic [31:0] w_addr;
    logic [7:0]  w_len, w_beat;
    logic [1:0]  w_burst;
    logic        w_err, w_bad;
    logic        w_fire, w_final, w_last_bad, w_we;

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = w_state;
        w_fire     = (w_state == W_DATA) && wvalid;
        w_final    = (w_beat == w_len);
        w_last_bad = w_fire && (wlast != w_final);
        // Once a burst is known bad, no further beat of it reaches the array.
        w_we       = w_fire && !w_err && !w_bad && !w_last_bad;
        case (w_state)
            W_IDLE:  if (awvalid) w_state_nx = W_DATA;
            W_DATA:  if (w_fire && w_final) w_state_nx = W_RESP;
            W_RESP:  if (bready) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_bad   <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            if (w_state == W_IDLE && awvalid) begin
                bid     <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_burst <= awburst;
                w_err   <= burst_err(awlen, awsize, awburst);
                w_bad   <= 1'b0;
                w_beat  <= 8'd0;
            end else if (w_fire) begin
                if (w_last_bad) w_bad <= 1'b1;
                if (w_final) begin
                    bresp <= (w_err || w_bad || w_last_bad) ? 2'b10 : 2'b00;
                end else begin
                    w_beat <= w_beat + 8'd1;
                    w_addr <= next_addr(w_addr, w_len, w_burst);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign awready = (w_state == W_IDLE) && !rst;
    assign wready  = (w_state == W_DATA) && !rst;
    assign bvalid  = (w_state == W_RESP) && !rst;
    assign arready = (r_state == R_IDLE) && !rst;
    assign rvalid  = (r_state == R_BURST) && !rst;

endmodule
